// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen: test-pattern source that sits behind vga_timing.
// Rebuilds the active pixel X/Y position from de/vsync strobes, selects one of
// several 24-bit test patterns (latched once per frame) and re-times the
// strobes so de/hsync/vsync/rgb all leave together, 2 clocks after input.
//
// Optional feature: define PATTERN_MOVING_BOX_EN to overlay a white
// BOX_SIZE x BOX_SIZE box that bounces one pixel per frame. BOX_SIZE exists
// only when the macro is defined.
//
// Ports
//   clk          pixel clock
//   rst          asynchronous reset, active-high
//   de_in        data enable (1 = active pixel)
//   hsync_in     horizontal sync, active-low
//   vsync_in     vertical sync, active-low
//   pattern_sel  pattern request, taken only at frame start
//   de_out       de_in delayed 2 clocks
//   hsync_out    hsync_in delayed 2 clocks
//   vsync_out    vsync_in delayed 2 clocks
//   rgb_out      {R,G,B}, black when blanking or not yet locked to a frame
//   frame_cnt    number of frame starts seen, wraps
module vga_pattern_gen #(
    parameter int unsigned H_ACTIVE  = 640,
    parameter int unsigned V_ACTIVE  = 480,
    parameter logic [23:0] SOLID_RGB = 24'h0000FF
`ifdef PATTERN_MOVING_BOX_EN
    ,
    parameter int unsigned BOX_SIZE  = 32
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        de_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic [2:0]  pattern_sel,
    output logic        de_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic [23:0] rgb_out,
    output logic [15:0] frame_cnt
);

    localparam int unsigned CW    = 12;
    localparam int unsigned BAR_W = H_ACTIVE / 8;
    localparam int unsigned X_MAX = H_ACTIVE - 1;
    localparam int unsigned Y_MAX = V_ACTIVE - 1;

    localparam logic [23:0] WHITE = 24'hFFFFFF;
    localparam logic [23:0] BLACK = 24'h000000;

    // Strobe history and position tracking
    logic          de_d;
    logic          vs_d;
    logic          fs_c;
    logic          le_c;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic [2:0]    pat;
    logic          locked;

    // Stage 1 registers
    logic [CW-1:0] x_s1;
    logic [CW-1:0] y_s1;
    logic          de_s1;
    logic          hs_s1;
    logic          vs_s1;
    logic [2:0]    pat_s1;
    logic          lock_s1;

    // Pattern evaluation
    logic [CW-1:0] bar_q;
    logic [2:0]    bar_idx;
    logic [23:0]   pattern_c;
    logic [23:0]   pixel_c;

    assign fs_c = vs_d & ~vsync_in;
    assign le_c = de_d & ~de_in;

    // Edge history, X/Y counters, frame count and per-frame pattern latch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            de_d      <= 1'b0;
            vs_d      <= 1'b1;
            x         <= '0;
            y         <= '0;
            frame_cnt <= '0;
            pat       <= '0;
            locked    <= 1'b0;
        end else begin
            de_d <= de_in;
            vs_d <= vsync_in;

            if (le_c) begin
                x <= '0;
            end else if (de_in && (x != CW'(X_MAX))) begin
                x <= x + CW'(1);
            end

            // Frame start overrides a coincident line end
            if (fs_c) begin
                y <= '0;
            end else if (le_c && (y != CW'(Y_MAX))) begin
                y <= y + CW'(1);
            end

            if (fs_c) begin
                frame_cnt <= frame_cnt + 16'd1;
                pat       <= pattern_sel;
                locked    <= 1'b1;
            end
        end
    end

    // Stage 1: capture position, strobes and the frame's pattern together
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_s1    <= '0;
            y_s1    <= '0;
            de_s1   <= 1'b0;
            hs_s1   <= 1'b1;
            vs_s1   <= 1'b1;
            pat_s1  <= '0;
            lock_s1 <= 1'b0;
        end else begin
            x_s1    <= x;
            y_s1    <= y;
            de_s1   <= de_in;
            hs_s1   <= hsync_in;
            vs_s1   <= vsync_in;
            pat_s1  <= pat;
            lock_s1 <= locked;
        end
    end

    // Pattern colour for the stage-1 pixel
    always_comb begin
        pattern_c = BLACK;
        bar_q     = x_s1 / CW'(BAR_W);
        bar_idx   = (bar_q > CW'(7)) ? 3'd7 : bar_q[2:0];

        case (pat_s1)
            3'd0: begin
                case (bar_idx)
                    3'd0:    pattern_c = 24'hFFFFFF;
                    3'd1:    pattern_c = 24'hFFFF00;
                    3'd2:    pattern_c = 24'h00FFFF;
                    3'd3:    pattern_c = 24'h00FF00;
                    3'd4:    pattern_c = 24'hFF00FF;
                    3'd5:    pattern_c = 24'hFF0000;
                    3'd6:    pattern_c = 24'h0000FF;
                    default: pattern_c = 24'h000000;
                endcase
            end
            3'd1:    pattern_c = (x_s1[5] ^ y_s1[5]) ? BLACK : WHITE;
            3'd2:    pattern_c = {x_s1[9:2], x_s1[9:2], x_s1[9:2]};
            3'd3: begin
                if ((x_s1[3:0] == 4'd0) || (y_s1[3:0] == 4'd0) ||
                    (x_s1 == CW'(X_MAX)) || (y_s1 == CW'(Y_MAX))) begin
                    pattern_c = WHITE;
                end
            end
            3'd4:    pattern_c = SOLID_RGB;
            default: pattern_c = BLACK;
        endcase
    end

`ifdef PATTERN_MOVING_BOX_EN
    // Bouncing box: position moves one pixel per frame start
    logic [CW-1:0] bx;
    logic [CW-1:0] by;
    logic          dir_x;   // 0 = +x, 1 = -x
    logic          dir_y;   // 0 = +y, 1 = -y
    logic [CW-1:0] bx_next;
    logic [CW-1:0] by_next;
    logic          dir_x_next;
    logic          dir_y_next;
    logic          in_box_c;

    // A blocked step flips direction and moves the other way in the same frame
    always_comb begin
        bx_next    = bx;
        by_next    = by;
        dir_x_next = dir_x;
        dir_y_next = dir_y;

        if (!dir_x) begin
            if (bx >= CW'(H_ACTIVE - BOX_SIZE)) begin
                dir_x_next = 1'b1;
                bx_next    = bx - CW'(1);
            end else begin
                bx_next    = bx + CW'(1);
            end
        end else begin
            if (bx == '0) begin
                dir_x_next = 1'b0;
                bx_next    = bx + CW'(1);
            end else begin
                bx_next    = bx - CW'(1);
            end
        end

        if (!dir_y) begin
            if (by >= CW'(V_ACTIVE - BOX_SIZE)) begin
                dir_y_next = 1'b1;
                by_next    = by - CW'(1);
            end else begin
                by_next    = by + CW'(1);
            end
        end else begin
            if (by == '0) begin
                dir_y_next = 1'b0;
                by_next    = by + CW'(1);
            end else begin
                by_next    = by - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bx    <= '0;
            by    <= '0;
            dir_x <= 1'b0;
            dir_y <= 1'b0;
        end else if (fs_c) begin
            bx    <= bx_next;
            by    <= by_next;
            dir_x <= dir_x_next;
            dir_y <= dir_y_next;
        end
    end

    assign in_box_c = (x_s1 >= bx) && (x_s1 < (bx + CW'(BOX_SIZE))) &&
                      (y_s1 >= by) && (y_s1 < (by + CW'(BOX_SIZE)));
    assign pixel_c  = in_box_c ? WHITE : pattern_c;
`else
    assign pixel_c  = pattern_c;
`endif

    // Stage 2: registered outputs; black outside active video or before lock
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            de_out    <= 1'b0;
            hsync_out <= 1'b1;
            vsync_out <= 1'b1;
            rgb_out   <= '0;
        end else begin
            de_out    <= de_s1;
            hsync_out <= hs_s1;
            vsync_out <= vs_s1;
            rgb_out   <= (de_s1 && lock_s1) ? pixel_c : BLACK;
        end
    end

endmodule
